// File: rtl/ode_step_scheduler.sv
// Sequences N explicit-Euler steps through an external fixed-latency ODE core,
// handing each step's result out on a valid/ready port and advancing time.
module ode_step_scheduler #(
  parameter int CORE_LAT = 64,
  parameter int STEPS_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STEPS_W-1:0] num_steps,
  input  logic [15:0]        h_in,
  input  logic [15:0]        t0_in,
  output logic               core_enable,
  output logic [15:0]        core_h,
  input  logic [15:0]        core_xnext,
  input  logic               core_error,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_x,
  output logic [15:0]        out_t,
  output logic [STEPS_W-1:0] out_step,
  output logic               busy,
  output logic               done,
  output logic               err_abort
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_EMIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [7:0] LAT_M1 = 8'(CORE_LAT - 1);

  logic [2:0]         state;
  logic [7:0]         cnt;
  logic [STEPS_W-1:0] n_steps;
  logic [STEPS_W-1:0] step;
  logic [STEPS_W-1:0] step_inc;
  logic [15:0]        t;
  logic [15:0]        h;
  logic               err_cap;
  logic               ovf_cap;
  logic [16:0]        sum;
  logic               t_ovf;
  logic [15:0]        t_sat;

  // Sign-extended add; overflow shows up as disagreement of the top two bits.
  always_comb begin
    sum   = {t[15], t} + {h[15], h};
    t_ovf = sum[16] ^ sum[15];
    t_sat = sum[15:0];
    if (t_ovf) t_sat = sum[16] ? 16'h8000 : 16'h7FFF;
  end

  assign step_inc    = step + STEPS_W'(1);
  assign core_h      = h;
  assign core_enable = (state == S_LAUNCH);
  assign out_valid   = (state == S_EMIT);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FINISH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      n_steps   <= '0;
      step      <= '0;
      t         <= '0;
      h         <= '0;
      err_cap   <= 1'b0;
      ovf_cap   <= 1'b0;
      out_x     <= '0;
      out_t     <= '0;
      out_step  <= '0;
      err_abort <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            err_abort <= 1'b0;
            if (num_steps != '0) begin
              n_steps <= num_steps;
              h       <= h_in;
              t       <= t0_in;
              step    <= '0;
              state   <= S_LAUNCH;
            end else begin
              state <= S_FINISH;
            end
          end
        end
        S_LAUNCH: begin
          cnt   <= LAT_M1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == 8'd0) begin
            out_x    <= core_xnext;
            err_cap  <= core_error;
            ovf_cap  <= t_ovf;
            out_t    <= t_sat;
            out_step <= step_inc;
            state    <= S_EMIT;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            t    <= out_t;
            step <= step_inc;
            if (err_cap || ovf_cap) begin
              err_abort <= 1'b1;
              state     <= S_FINISH;
            end else if (step_inc == n_steps) begin
              state <= S_FINISH;
            end else begin
              state <= S_LAUNCH;
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ode_step_scheduler.sv
// Scoreboard bench: a queue of expected step results is filled per run and
// drained by a monitor; a core model returns data only in its valid cycle.
module tb_ode_step_scheduler;

  localparam int L  = 4;
  localparam int SW = 8;

  typedef struct packed {
    logic [15:0]   x;
    logic [15:0]   t;
    logic [SW-1:0] step;
  } res_t;

  logic          clk = 0;
  logic          rst = 1;
  logic          start = 0;
  logic [SW-1:0] num_steps = '0;
  logic [15:0]   h_in = '0;
  logic [15:0]   t0_in = '0;
  logic          core_enable;
  logic [15:0]   core_h;
  logic [15:0]   core_xnext = '0;
  logic          core_error = 0;
  logic          out_valid;
  logic          out_ready = 0;
  logic [15:0]   out_x;
  logic [15:0]   out_t;
  logic [SW-1:0] out_step;
  logic          busy;
  logic          done;
  logic          err_abort;

  ode_step_scheduler #(.CORE_LAT(L), .STEPS_W(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_steps(num_steps),
    .h_in(h_in), .t0_in(t0_in), .core_enable(core_enable),
    .core_h(core_h), .core_xnext(core_xnext), .core_error(core_error),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_t(out_t), .out_step(out_step), .busy(busy), .done(done),
    .err_abort(err_abort)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  res_t        exp_q[$];
  logic [15:0] run_x[$];
  bit          run_err[$];
  int          launch_idx = 0;
  int          popped = 0;
  int          mode = 0;
  int          stall = 0;
  int          cyc = 0;
  int          launch_cyc = -100;
  int          prev_launch = -100;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] sat_add(input logic [15:0] a,
                                          input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767) return {1'b1, 16'h7FFF};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(s)};
  endfunction

  // Core model: data is meaningful only in the cycle L after the launch cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      launch_cyc = -100;
    end else if (core_enable) begin
      launch_idx++;
      chk("launch_order", 64'(launch_idx), 64'(popped + 1));
      if (mode == 0 && launch_idx > 1)
        chk("enable_gap", 64'(cyc - prev_launch), 64'(L + 2));
      prev_launch = cyc;
      launch_cyc = cyc;
    end
    if (cyc == launch_cyc + L && launch_idx >= 1 &&
        launch_idx <= run_x.size()) begin
      core_xnext = run_x[launch_idx-1];
      core_error = run_err[launch_idx-1];
    end else begin
      core_xnext = 16'($urandom);
      core_error = 1'($urandom);
    end
  end

  // Monitor: checks every valid cycle against the queue head, owns out_ready.
  always @(negedge clk) begin
    bit r;
    res_t e;
    if (rst) begin
      out_ready = 0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_valid: got step %0d expected none",
                 out_step);
        out_ready = 1;
      end else begin
        e = exp_q[0];
        chk("out_x", 64'(out_x), 64'(e.x));
        chk("out_t", 64'(out_t), 64'(e.t));
        chk("out_step", 64'(out_step), 64'(e.step));
        case (mode)
          0: r = 1;
          1: r = 1'($urandom_range(0, 1));
          default: begin
            if (e.step == 2 && stall < 10) begin
              r = 0;
              stall++;
            end else r = 1;
          end
        endcase
        out_ready = r;
        if (r) begin
          e = exp_q.pop_front();
          popped++;
        end
      end
    end else begin
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic prep(input int n, input logic [15:0] hh,
                      input logic [15:0] tt, input int errstep,
                      output bit abort, output int en);
    logic [16:0] r;
    logic [15:0] t;
    run_x.delete();
    run_err.delete();
    exp_q.delete();
    launch_idx = 0;
    popped = 0;
    stall = 0;
    for (int i = 0; i < n; i++) begin
      run_x.push_back(16'($urandom));
      run_err.push_back(i + 1 == errstep);
    end
    t = tt;
    abort = 0;
    en = 0;
    for (int i = 1; i <= n && !abort; i++) begin
      en++;
      r = sat_add(t, hh);
      exp_q.push_back('{x: run_x[i-1], t: r[15:0], step: SW'(i)});
      if (run_err[i-1] || r[16]) abort = 1;
      t = r[15:0];
    end
  endtask

  task automatic run(input int n, input logic [15:0] hh,
                     input logic [15:0] tt, input int errstep,
                     input int m);
    bit abort;
    int en;
    int k;
    bit got;
    mode = m;
    prep(n, hh, tt, errstep, abort, en);
    @(negedge clk);
    start = 1;
    num_steps = SW'(n);
    h_in = hh;
    t0_in = tt;
    @(negedge clk);
    start = 0;
    num_steps = SW'($urandom);
    h_in = 16'($urandom);
    t0_in = 16'($urandom);
    chk("err_clear", 64'(err_abort), 64'(0));
    k = 1;
    got = 0;
    while (k < 4000) begin
      if (done) begin
        got = 1;
        break;
      end
      if (k == 3 && n > 0) chk("core_h", 64'(core_h), 64'(hh));
      start = (k == 2 && n > 0);
      @(negedge clk);
      k++;
    end
    start = 0;
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got no done expected done");
    end
    if (n == 0) chk("zero_done_lat", 64'(k), 64'(1));
    chk("err_abort", 64'(err_abort), 64'(abort));
    chk("enables", 64'(launch_idx), 64'(en));
    chk("drained", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'(0));
    chk("idle", 64'(busy), 64'(0));
  endtask

  initial begin
    bit ab;
    int en;
    int n;
    int es;
    logic [15:0] hh;
    @(negedge clk);
    chk("rst_state", {core_enable, core_h, out_valid, out_x, out_t,
                      out_step, busy, done, err_abort}, 64'(0));
    rst = 0;
    run(3, 16'h0100, 16'h0000, 0, 0);
    run(3, 16'h0100, 16'h0000, 0, 2);
    run(5, 16'h0100, 16'h0000, 2, 0);
    run(0, 16'h0100, 16'h0000, 0, 0);
    run(3, 16'h0100, 16'h7F00, 0, 0);
    run(2, 16'hFF00, 16'h8080, 0, 1);

    mode = 0;
    prep(3, 16'h0100, 16'h0040, 0, ab, en);
    @(negedge clk);
    start = 1;
    num_steps = 3;
    h_in = 16'h0100;
    t0_in = 16'h0040;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_wait_busy", 64'(busy), 64'(1));
    rst = 1;
    #1;
    chk("rst_outputs", {core_enable, core_h, out_valid, out_x, out_t,
                        out_step, busy, done, err_abort}, 64'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 0;
    run(3, 16'h0080, 16'h0040, 0, 0);

    for (int i = 0; i < 20; i++) begin
      n = $urandom_range(0, 12);
      es = ($urandom_range(0, 3) == 0 && n > 0) ? $urandom_range(1, n) : 0;
      hh = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                       : 16'($urandom_range(0, 16'h0800));
      run(n, hh, 16'($urandom), es, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ode_step_scheduler.md
ODE_STEP_SCHEDULER -- requirements
Module: ode_step_scheduler

Interface
REQ-001 Parameter CORE_LAT, default 64: cycles from the core_enable pulse to a valid core_xnext/core_error, range 1..255.
REQ-002 Parameter STEPS_W, default 8: width of the step count.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: request a run; sampled in IDLE only.
REQ-006 Port num_steps, input, STEPS_W: number of Euler steps; latched on an accepted start.
REQ-007 Port h_in, input, 16: step size, Q9.7 signed; latched on an accepted start.
REQ-008 Port t0_in, input, 16: start time, Q9.7 signed; latched on an accepted start.
REQ-009 Port core_enable, output, 1: one-cycle launch pulse to the ODE core.
REQ-010 Port core_h, output, 16: latched h, held stable for the whole run.
REQ-011 Port core_xnext, input, 16: core result, Q9.7.
REQ-012 Port core_error, input, 1: core overflow flag.
REQ-013 Port out_valid, output, 1; port out_ready, input, 1: result handshake.
REQ-014 Port out_x, output, 16; port out_t, output, 16; port out_step, output, STEPS_W: per-step result payload.
REQ-015 Port busy, output, 1; port done, output, 1; port err_abort, output, 1: status.

Function
REQ-016 The FSM SHALL have the states IDLE, LAUNCH, WAIT, EMIT, FINISH.
REQ-017 IDLE: start=1 with num_steps>0 SHALL latch the inputs, clear step and t=t0, and go to LAUNCH.
- start=1 with num_steps=0 SHALL go to FINISH with no core_enable.
REQ-018 LAUNCH SHALL assert core_enable for exactly one cycle, load wait counter = CORE_LAT-1, and go to WAIT.
REQ-019 WAIT SHALL decrement the counter each cycle; at 0 it SHALL capture core_xnext, core_error and t_next = t+h, and go to EMIT.
- The first result is therefore sampled CORE_LAT+1 cycles after the LAUNCH cycle begins.
REQ-020 t_next SHALL be a 16-bit signed add that saturates to 0x7FFF or 0x8000 on overflow and sets the internal flag t_ovf.
REQ-021 EMIT SHALL hold out_valid=1 with out_x, out_t=t_next and out_step=step+1 stable until out_ready=1.
- The payload SHALL NOT change while out_valid=1 and out_ready=0.
REQ-022 On the handshake cycle (out_valid & out_ready):
- t SHALL update and step SHALL increment.
- If captured core_error or t_ovf: set err_abort and go to FINISH.
- Else if step+1==num_steps: go to FINISH.
- Else: go to LAUNCH.
REQ-023 FINISH SHALL pulse done for one cycle and return to IDLE.
- err_abort SHALL hold until the next accepted start, which clears it.
REQ-024 busy SHALL be 1 in every state except IDLE.
- start while busy SHALL be ignored.
- h_in, t0_in and num_steps changes while busy SHALL have no effect.
REQ-025 An abort SHALL still emit the failing step's result before FINISH.

Reset
REQ-026 rst=1 SHALL immediately force IDLE and set every output to 0: core_enable, core_h, out_valid, out_x, out_t, out_step, busy, done, err_abort.
REQ-027 Reset in any state, including mid-WAIT, SHALL abandon the run with no done pulse; the next start SHALL begin cleanly.

Verification
REQ-028 CORE_LAT=4, h=0x0100, t0=0, num_steps=3, out_ready=1 -> three core_enable pulses, 6 cycles apart; out_t=0x0100, 0x0200, 0x0300; out_step=1,2,3; one done; err_abort=0.
REQ-029 Same run with out_ready=0 for 10 cycles at step 2 -> out_valid and payload held; no core_enable until the handshake completes.
REQ-030 core_error=1 at step 2 of 5 -> step 2 emitted, err_abort=1, done pulse, only 2 core_enable pulses.
REQ-031 num_steps=0 -> done one cycle after start; core_enable never asserted; out_valid never asserted.
REQ-032 t0=0x7F00, h=0x0100 -> out_t=0x7FFF, err_abort=1 after step 1.
REQ-033 rst asserted mid-WAIT -> all outputs 0 immediately; a new start with h=0x0080 runs normally, with out_t starting at t0+0x0080.
